// File: rtl/rs_pkg.sv
// Shared reservation-station types: the per-entry record and the default widths
// that dispatch, the CDB arbiter and the reservation station agree on.
package rs_pkg;

  localparam int RS_DATA_W  = 32;
  localparam int RS_TAG_W   = 3;
  localparam int RS_OP_W    = 5;
  localparam int RS_NUM_OPS = 3;

  typedef struct packed {
    logic                                 valid;
    logic [RS_OP_W-1:0]                   op;
    logic [RS_TAG_W-1:0]                  dst_tag;
    logic [RS_NUM_OPS-1:0][RS_DATA_W-1:0] op_val;
    logic [RS_NUM_OPS-1:0][RS_TAG_W-1:0]  op_tag;
    logic [RS_NUM_OPS-1:0]                op_rdy;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_ready_sel.sv
// Priority encoder: reports whether any entry is ready and the lowest (oldest)
// ready index.
module rs_oldest_ready_sel #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready_vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the youngest slot down so the oldest ready slot is written last
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx   = ready_vec[i] ? IDX_W'(i) : idx;
      found = found | ready_vec[i];
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Age-ordered reservation station with CDB wakeup and oldest-ready issue.
// Entry widths follow rs_pkg. RS_OCCUPANCY_EN adds rs_count and rs_full_cycles.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int OP_W   = RS_OP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAG_W-1:0]           disp_dst_tag,
  input  logic [DATA_W-1:0]          disp_op1_val,
  input  logic [DATA_W-1:0]          disp_op2_val,
  input  logic [DATA_W-1:0]          disp_op3_val,
  input  logic [TAG_W-1:0]           disp_op1_tag,
  input  logic [TAG_W-1:0]           disp_op2_tag,
  input  logic [TAG_W-1:0]           disp_op3_tag,
  input  logic                       disp_op1_ready,
  input  logic                       disp_op2_ready,
  input  logic                       disp_op3_ready,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_value,
`ifdef RS_OCCUPANCY_EN
  output logic [$clog2(DEPTH+1)-1:0] rs_count,
  output logic [15:0]                rs_full_cycles,
`endif
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [OP_W-1:0]            issue_op,
  output logic [TAG_W-1:0]           issue_dst_tag,
  output logic [DATA_W-1:0]          issue_op1,
  output logic [DATA_W-1:0]          issue_op2,
  output logic [DATA_W-1:0]          issue_op3
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        ent_r  [DEPTH];
  rs_entry_t        wake_s [DEPTH+1];
  rs_entry_t        next_s [DEPTH];
  rs_entry_t        new_s;
  rs_entry_t        sel_ent_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] wr_idx_s;
  logic [DEPTH-1:0] rdy_vec_s;
  logic             found_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             issue_fire_s;
  logic             disp_fire_s;

  assign disp_ready   = (count_r < CNT_W'(DEPTH));
  assign disp_fire_s  = disp_valid & disp_ready;
  assign issue_fire_s = found_s & issue_ready;
  assign count_next_s = count_r + CNT_W'(disp_fire_s) - CNT_W'(issue_fire_s);
  // An issue in the same cycle frees the tail slot the new entry lands in
  assign wr_idx_s     = count_r - CNT_W'(issue_fire_s);

  // Per-entry "fully ready" vector feeding the oldest-ready selector
  always_comb begin
    rdy_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec_s[i] = ent_r[i].valid & (&ent_r[i].op_rdy);
    end
  end

  rs_oldest_ready_sel #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .ready_vec (rdy_vec_s),
    .found     (found_s),
    .idx       (sel_idx_s)
  );

  // CDB capture on stored entries; only waiting operands may take the value
  always_comb begin
    for (int i = 0; i <= DEPTH; i++) begin
      wake_s[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      wake_s[i] = ent_r[i];
      for (int k = 0; k < RS_NUM_OPS; k++) begin
        if (cdb_valid && ent_r[i].valid && !ent_r[i].op_rdy[k] &&
            (ent_r[i].op_tag[k] == cdb_tag)) begin
          wake_s[i].op_val[k] = cdb_value;
          wake_s[i].op_rdy[k] = 1'b1;
        end else begin
          wake_s[i].op_rdy[k] = ent_r[i].op_rdy[k];
        end
      end
    end
  end

  // Incoming entry with same-cycle CDB bypass so no wakeup is lost
  always_comb begin
    new_s         = '0;
    new_s.valid   = 1'b1;
    new_s.op      = disp_op;
    new_s.dst_tag = disp_dst_tag;
    new_s.op_val  = {disp_op3_val, disp_op2_val, disp_op1_val};
    new_s.op_tag  = {disp_op3_tag, disp_op2_tag, disp_op1_tag};
    new_s.op_rdy  = {disp_op3_ready, disp_op2_ready, disp_op1_ready};
    for (int k = 0; k < RS_NUM_OPS; k++) begin
      if (cdb_valid && !new_s.op_rdy[k] && (new_s.op_tag[k] == cdb_tag)) begin
        new_s.op_val[k] = cdb_value;
        new_s.op_rdy[k] = 1'b1;
      end else begin
        new_s.op_rdy[k] = new_s.op_rdy[k];
      end
    end
  end

  // Compaction over the issued slot, then dispatch into the tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire_s && (i == int'(wr_idx_s))) begin
        next_s[i] = new_s;
      end else if (issue_fire_s && (i >= int'(sel_idx_s))) begin
        next_s[i] = wake_s[i+1];
      end else begin
        next_s[i] = wake_s[i];
      end
    end
  end

  // Issue mux: zero when nothing is ready
  always_comb begin
    sel_ent_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_ent_s = (found_s && (i == int'(sel_idx_s))) ? ent_r[i] : sel_ent_s;
    end
  end

  assign issue_valid   = found_s;
  assign issue_op      = sel_ent_s.op;
  assign issue_dst_tag = sel_ent_s.dst_tag;
  assign issue_op1     = sel_ent_s.op_val[0];
  assign issue_op2     = sel_ent_s.op_val[1];
  assign issue_op3     = sel_ent_s.op_val[2];

  // Entry storage and occupancy; flush outranks dispatch and issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else if (flush) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else begin
      count_r <= count_next_s;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= next_s[i];
      end
    end
  end

`ifdef RS_OCCUPANCY_EN
  logic [15:0] full_cycles_r;

  // Saturating count of full cycles; deliberately survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cycles_r <= 16'd0;
    end else if ((count_r == CNT_W'(DEPTH)) && (full_cycles_r != 16'hFFFF)) begin
      full_cycles_r <= full_cycles_r + 16'd1;
    end else begin
      full_cycles_r <= full_cycles_r;
    end
  end

  assign rs_count       = count_r;
  assign rs_full_cycles = full_cycles_r;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed by
// random traffic, all checked against a queue-based age-ordered model.
module tb_reservation_station;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_valid, disp_ready;
  logic [4:0]  disp_op;
  logic [2:0]  disp_dst_tag;
  logic [31:0] disp_op1_val, disp_op2_val, disp_op3_val;
  logic [2:0]  disp_op1_tag, disp_op2_tag, disp_op3_tag;
  logic        disp_op1_ready, disp_op2_ready, disp_op3_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_op;
  logic [2:0]  issue_dst_tag;
  logic [31:0] issue_op1, issue_op2, issue_op3;
`ifdef RS_OCCUPANCY_EN
  logic [2:0]  rs_count;
  logic [15:0] rs_full_cycles;
  logic [15:0] full_cnt = 16'd0;
`endif

  always #5 clk = ~clk;

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_dst_tag(disp_dst_tag),
    .disp_op1_val(disp_op1_val), .disp_op2_val(disp_op2_val), .disp_op3_val(disp_op3_val),
    .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag), .disp_op3_tag(disp_op3_tag),
    .disp_op1_ready(disp_op1_ready), .disp_op2_ready(disp_op2_ready),
    .disp_op3_ready(disp_op3_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
`ifdef RS_OCCUPANCY_EN
    .rs_count(rs_count), .rs_full_cycles(rs_full_cycles),
`endif
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_op3(issue_op3)
  );

  typedef struct packed {
    logic [4:0]       op;
    logic [2:0]       dst;
    logic [2:0][31:0] val;
    logic [2:0][2:0]  tag;
    logic [2:0]       rdy;
  } m_ent_t;

  m_ent_t mq[$];   // index 0 = oldest
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if (&mq[i].rdy) return i;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int si;
    m_ent_t e;
    si = model_sel();
    e = '0;
    if (si >= 0) e = mq[si];
    check_eq("disp_ready", disp_ready, mq.size() < DEPTH);
    check_eq("issue_valid", issue_valid, si >= 0);
    check_eq("issue_op", issue_op, e.op);
    check_eq("issue_dst_tag", issue_dst_tag, e.dst);
    check_eq("issue_op1", issue_op1, e.val[0]);
    check_eq("issue_op2", issue_op2, e.val[1]);
    check_eq("issue_op3", issue_op3, e.val[2]);
`ifdef RS_OCCUPANCY_EN
    check_eq("rs_count", rs_count, mq.size());
    check_eq("rs_full_cycles", rs_full_cycles, full_cnt);
`endif
  endtask

  // Advance the model by one clock using the currently driven inputs, then check.
  task automatic step();
    int si;
    bit fire, acc;
    m_ent_t ne;
    si   = model_sel();
    fire = (si >= 0) && issue_ready;
    acc  = disp_valid && (mq.size() < DEPTH);
`ifdef RS_OCCUPANCY_EN
    if (mq.size() == DEPTH && full_cnt != 16'hFFFF) full_cnt++;
`endif
    if (flush) begin
      mq.delete();
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          for (int k = 0; k < 3; k++) begin
            if (!mq[i].rdy[k] && mq[i].tag[k] == cdb_tag) begin
              mq[i].val[k] = cdb_value;
              mq[i].rdy[k] = 1'b1;
            end
          end
        end
      end
      if (fire) mq.delete(si);
      if (acc) begin
        ne.op  = disp_op;
        ne.dst = disp_dst_tag;
        ne.val = {disp_op3_val, disp_op2_val, disp_op1_val};
        ne.tag = {disp_op3_tag, disp_op2_tag, disp_op1_tag};
        ne.rdy = {disp_op3_ready, disp_op2_ready, disp_op1_ready};
        for (int k = 0; k < 3; k++) begin
          if (cdb_valid && !ne.rdy[k] && ne.tag[k] == cdb_tag) begin
            ne.val[k] = cdb_value;
            ne.rdy[k] = 1'b1;
          end
        end
        mq.push_back(ne);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_op = 5'd0; disp_dst_tag = 3'd0;
    disp_op1_val = 32'd0; disp_op2_val = 32'd0; disp_op3_val = 32'd0;
    disp_op1_tag = 3'd0; disp_op2_tag = 3'd0; disp_op3_tag = 3'd0;
    disp_op1_ready = 1'b0; disp_op2_ready = 1'b0; disp_op3_ready = 1'b0;
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_value = 32'd0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [2:0] dst,
                      input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
                      input logic [2:0] t1, input logic [2:0] t2, input logic [2:0] t3,
                      input logic [2:0] rdy);
    disp_valid = 1'b1; disp_op = op; disp_dst_tag = dst;
    disp_op1_val = v1; disp_op2_val = v2; disp_op3_val = v3;
    disp_op1_tag = t1; disp_op2_tag = t2; disp_op3_tag = t3;
    disp_op1_ready = rdy[0]; disp_op2_ready = rdy[1]; disp_op3_ready = rdy[2];
  endtask

  task automatic cdb(input logic [2:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
  endtask

  initial begin
    idle();
    issue_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Single fully-ready dispatch issues next cycle and leaves
    issue_ready = 1'b1;
    disp(5'd5, 3'd2, 32'h11, 32'h22, 32'h33, 3'd0, 3'd0, 3'd0, 3'b111);
    step();
    check_eq("t1_valid", issue_valid, 1'b1);
    check_eq("t1_op1", issue_op1, 32'h11);
    check_eq("t1_dst", issue_dst_tag, 3'd2);
    idle(); step();
    check_eq("t1_empty", issue_valid, 1'b0);

    // Wakeup: wrong tag ignored, matching tag wakes next cycle
    disp(5'd6, 3'd1, 32'h0, 32'h44, 32'h55, 3'd3, 3'd0, 3'd0, 3'b110);
    step();
    idle(); cdb(3'd4, 32'h1234); step();
    check_eq("t2_nowake", issue_valid, 1'b0);
    idle(); cdb(3'd3, 32'hDEAD); step();
    check_eq("t2_wake", issue_valid, 1'b1);
    check_eq("t2_op1", issue_op1, 32'hDEAD);
    idle(); step();

    // Dispatch/CDB same-cycle bypass
    disp(5'd7, 3'd3, 32'h1, 32'h0, 32'h3, 3'd0, 3'd6, 3'd0, 3'b101);
    cdb(3'd6, 32'hBEEF);
    step();
    check_eq("t3_valid", issue_valid, 1'b1);
    check_eq("t3_op2", issue_op2, 32'hBEEF);
    idle(); step();

    // Fill, overflow ignored, younger ready entries bypass the blocked oldest
    issue_ready = 1'b0;
    disp(5'd1, 3'd1, 32'h0, 32'hA2, 32'hA3, 3'd1, 3'd0, 3'd0, 3'b110); step();
    disp(5'd2, 3'd2, 32'hB1, 32'hB2, 32'hB3, 3'd0, 3'd0, 3'd0, 3'b111); step();
    disp(5'd3, 3'd3, 32'hC1, 32'hC2, 32'hC3, 3'd0, 3'd0, 3'd0, 3'b111); step();
    disp(5'd4, 3'd4, 32'hD1, 32'hD2, 32'hD3, 3'd0, 3'd0, 3'd0, 3'b111); step();
    check_eq("t4_full", disp_ready, 1'b0);
    disp(5'd9, 3'd5, 32'hE1, 32'hE2, 32'hE3, 3'd0, 3'd0, 3'd0, 3'b111); step();
    check_eq("t4_first", issue_op, 5'd2);
    idle(); issue_ready = 1'b1; step();
    check_eq("t4_second", issue_op, 5'd3);
    step();
    check_eq("t4_third", issue_op, 5'd4);
    step();
    check_eq("t4_blocked", issue_valid, 1'b0);
    cdb(3'd1, 32'hA1); step();
    check_eq("t4_last", issue_op, 5'd1);
    check_eq("t4_last_op1", issue_op1, 32'hA1);
    idle(); step();

    // Backpressure hold, then issue and dispatch together
    issue_ready = 1'b0;
    disp(5'd10, 3'd1, 32'h71, 32'h72, 32'h73, 3'd0, 3'd0, 3'd0, 3'b111); step();
    disp(5'd11, 3'd2, 32'h81, 32'h0, 32'h83, 3'd0, 3'd5, 3'd0, 3'b101); step();
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("t5_hold", issue_op, 5'd10);
    end
    issue_ready = 1'b1;
    disp(5'd12, 3'd3, 32'h91, 32'h92, 32'h93, 3'd0, 3'd0, 3'd0, 3'b111); step();
    check_eq("t5_tail", issue_op, 5'd12);
    check_eq("t5_ready", disp_ready, 1'b1);

    // Flush with concurrent dispatch
    idle(); flush = 1'b1; step();
    idle(); issue_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      disp(5'(c + 13), 3'(c), 32'(c), 32'h5, 32'h6, 3'd0, 3'd0, 3'd0, 3'b111); step();
    end
    flush = 1'b1; step();
    check_eq("t6_flush_valid", issue_valid, 1'b0);
    check_eq("t6_flush_ready", disp_ready, 1'b1);

    // Asynchronous reset in the middle of a wakeup cycle
    idle();
    disp(5'd20, 3'd4, 32'h0, 32'h1, 32'h2, 3'd2, 3'd0, 3'd0, 3'b110); step();
    idle(); cdb(3'd2, 32'hCAFE);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
`ifdef RS_OCCUPANCY_EN
    full_cnt = 16'd0;
`endif
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    idle();
    step();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      issue_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6) begin
        disp(5'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             3'($urandom), 3'($urandom), 3'($urandom),
             {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)});
      end
      if ($urandom_range(0, 9) < 4) cdb(3'($urandom), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
